// File: rtl/cdb_pkg.sv
// Shared constants, requester indices and the round-robin pick helper for the
// common-data-bus scheduler.
package cdb_pkg;

  localparam int CDB_ROB_W  = 4;
  localparam int CDB_FIFO_W = 2;
  localparam int NUM_REQ    = 3;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t REQ_ALU = 2'd0;
  localparam req_idx_t REQ_LSB = 2'd1;
  localparam req_idx_t REQ_MUL = 2'd2;

  typedef struct packed {
    logic [31:0]          val;
    logic [CDB_ROB_W-1:0] dest;
  } cdb_entry_t;

  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } grant_t;

  // Search starts at the requester after the last winner; the first requesting
  // entry in that order wins.
  function automatic grant_t rr_pick(input req_idx_t last, input logic [NUM_REQ-1:0] req);
    req_idx_t order [NUM_REQ];
    grant_t   g;
    case (last)
      REQ_LSB: order = '{REQ_MUL, REQ_ALU, REQ_LSB};
      REQ_MUL: order = '{REQ_ALU, REQ_LSB, REQ_MUL};
      default: order = '{REQ_LSB, REQ_MUL, REQ_ALU};
    endcase
    g.valid = 1'b0;
    g.idx   = REQ_ALU;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[order[i]]) begin
        g.valid = 1'b1;
        g.idx   = order[i];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// One requester's result queue: circular buffer with registered count.
// Full/empty decode from registered count only, so a pop never frees a slot
// for a push in the same cycle.
module cdb_fifo #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ready_i,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_ok_s = ready_i & ~clear_i & push_i & ~full_o;
  assign pop_ok_s  = ready_i & ~clear_i & pop_i & ~empty_o;
  assign head_o    = mem_q[head_q];

  // Pointer and occupancy next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (ready_i && clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok_s) tail_d = tail_q + ADDR_W'(1);
      else           tail_d = tail_q;
      if (pop_ok_s)  head_d = head_q + ADDR_W'(1);
      else           head_d = head_q;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok_s) begin
      mem_q[tail_q] <= data_i;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus scheduler: three result queues, round-robin grant from
// registered queue state, one registered broadcast per cycle.
module cdb_arbiter import cdb_pkg::*; #(
  parameter int ROB_WIDTH  = CDB_ROB_W,
  parameter int FIFO_WIDTH = CDB_FIFO_W
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 clearIn,
  input  logic                 aluFlag,
  input  logic [31:0]          aluVal,
  input  logic [ROB_WIDTH-1:0] aluDest,
  output logic                 aluFull,
  input  logic                 lsbFlag,
  input  logic [31:0]          lsbVal,
  input  logic [ROB_WIDTH-1:0] lsbDest,
  output logic                 lsbFull,
  input  logic                 mulFlag,
  input  logic [31:0]          mulVal,
  input  logic [ROB_WIDTH-1:0] mulDest,
  output logic                 mulFull,
  output logic                 outFlag,
  output logic [31:0]          outVal,
  output logic [ROB_WIDTH-1:0] outDest,
  output logic                 overflowOut
);

  localparam int DATA_W = 32 + ROB_WIDTH;

  logic [NUM_REQ-1:0] push_s, pop_s, empty_s, full_s;
  logic [DATA_W-1:0]  wdata_s [NUM_REQ];
  logic [DATA_W-1:0]  head_s  [NUM_REQ];
  logic [DATA_W-1:0]  gnt_data_s;
  grant_t             gnt_s;
  logic               advance_s;

  logic                 out_flag_q, out_flag_d;
  logic [31:0]          out_val_q, out_val_d;
  logic [ROB_WIDTH-1:0] out_dest_q, out_dest_d;
  req_idx_t             rr_q, rr_d;
  logic                 overflow_q, overflow_d;

  assign push_s           = {mulFlag, lsbFlag, aluFlag};
  assign wdata_s[REQ_ALU] = {aluVal, aluDest};
  assign wdata_s[REQ_LSB] = {lsbVal, lsbDest};
  assign wdata_s[REQ_MUL] = {mulVal, mulDest};
  assign advance_s        = readyIn & ~clearIn;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    cdb_fifo #(.DATA_W(DATA_W), .ADDR_W(FIFO_WIDTH)) u_fifo (
      .clk_i   (clockIn),
      .rst_ni  (resetIn),
      .ready_i (readyIn),
      .clear_i (clearIn),
      .push_i  (push_s[g]),
      .data_i  (wdata_s[g]),
      .pop_i   (pop_s[g]),
      .head_o  (head_s[g]),
      .empty_o (empty_s[g]),
      .full_o  (full_s[g])
    );
  end

  assign aluFull = full_s[REQ_ALU];
  assign lsbFull = full_s[REQ_LSB];
  assign mulFull = full_s[REQ_MUL];

  // Winner selection and head mux.
  always_comb begin
    gnt_s = rr_pick(rr_q, ~empty_s);
    case (gnt_s.idx)
      REQ_LSB: gnt_data_s = head_s[REQ_LSB];
      REQ_MUL: gnt_data_s = head_s[REQ_MUL];
      default: gnt_data_s = head_s[REQ_ALU];
    endcase
  end

  // One-hot pop of the winning queue.
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pop_s[i] = advance_s & gnt_s.valid & (gnt_s.idx == req_idx_t'(i));
    end
  end

  // Broadcast, pointer and overflow next state; a clear suppresses the grant.
  always_comb begin
    out_flag_d = out_flag_q;
    out_val_d  = out_val_q;
    out_dest_d = out_dest_q;
    rr_d       = rr_q;
    overflow_d = overflow_q;
    if (readyIn && clearIn) begin
      out_flag_d = 1'b0;
      rr_d       = REQ_ALU;
    end else if (readyIn) begin
      overflow_d = overflow_q | (|(push_s & full_s));
      if (gnt_s.valid) begin
        out_flag_d              = 1'b1;
        {out_val_d, out_dest_d} = gnt_data_s;
        rr_d                    = gnt_s.idx;
      end else begin
        out_flag_d = 1'b0;
      end
    end else begin
      out_flag_d = out_flag_q;
    end
  end

  // Output and arbitration registers.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      out_flag_q <= 1'b0;
      out_val_q  <= 32'd0;
      out_dest_q <= '0;
      rr_q       <= REQ_ALU;
      overflow_q <= 1'b0;
    end else begin
      out_flag_q <= out_flag_d;
      out_val_q  <= out_val_d;
      out_dest_q <= out_dest_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
    end
  end

  assign outFlag     = out_flag_q;
  assign outVal      = out_val_q;
  assign outDest     = out_dest_q;
  assign overflowOut = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic        clk, rst_n, ready, clear;
  logic        alu_f, lsb_f, mul_f;
  logic [31:0] alu_v, lsb_v, mul_v;
  logic [3:0]  alu_d, lsb_d, mul_d;
  logic        alu_full, lsb_full, mul_full;
  logic        out_f, ovf;
  logic [31:0] out_v;
  logic [3:0]  out_d;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter dut (
    .clockIn(clk), .resetIn(rst_n), .readyIn(ready), .clearIn(clear),
    .aluFlag(alu_f), .aluVal(alu_v), .aluDest(alu_d), .aluFull(alu_full),
    .lsbFlag(lsb_f), .lsbVal(lsb_v), .lsbDest(lsb_d), .lsbFull(lsb_full),
    .mulFlag(mul_f), .mulVal(mul_v), .mulDest(mul_d), .mulFull(mul_full),
    .outFlag(out_f), .outVal(out_v), .outDest(out_d), .overflowOut(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic f, input logic [31:0] v, input logic [3:0] d);
    check_eq({tag, ".flag"}, 64'(out_f), 64'(f));
    if (f) begin
      check_eq({tag, ".val"}, 64'(out_v), 64'(v));
      check_eq({tag, ".dest"}, 64'(out_d), 64'(d));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_f = 1'b0; lsb_f = 1'b0; mul_f = 1'b0; clear = 1'b0;
  endtask

  task automatic push_all(input logic [31:0] va, input logic [3:0] da,
                          input logic [31:0] vl, input logic [3:0] dl,
                          input logic [31:0] vm, input logic [3:0] dm);
    alu_f = 1'b1; alu_v = va; alu_d = da;
    lsb_f = 1'b1; lsb_v = vl; lsb_d = dl;
    mul_f = 1'b1; mul_v = vm; mul_d = dm;
  endtask

  // Broadcast j of the 5-round fill pattern started with the pointer at ALU:
  // LSB, MUL, ALU repeating, round k = j/3.
  function automatic logic [35:0] exp_seq(input int j);
    int k;
    k = j / 3;
    case (j % 3)
      0:       return {32'hB0 + 32'(k), 4'(5 + k)};
      1:       return {32'hC0 + 32'(k), 4'(10 + k)};
      default: return {32'hA0 + 32'(k), 4'(k)};
    endcase
  endfunction

  task automatic check_seq(input int j);
    logic [35:0] e;
    e = exp_seq(j);
    check_out($sformatf("seq%0d", j), 1'b1, e[35:4], e[3:0]);
  endtask

  // Push all three queues for 5 cycles; ALU and MUL end up full.
  task automatic fill();
    for (int k = 0; k < 5; k++) begin
      push_all(32'hA0 + 32'(k), 4'(k), 32'hB0 + 32'(k), 4'(5 + k), 32'hC0 + 32'(k), 4'(10 + k));
      tick();
      if (k == 0) check_out("fill0", 1'b0, 32'd0, 4'd0);
      else        check_seq(k - 1);
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b1; ready = 1'b1;
    alu_v = 32'd0; lsb_v = 32'd0; mul_v = 32'd0;
    alu_d = 4'd0;  lsb_d = 4'd0;  mul_d = 4'd0;
    idle();
    #1 rst_n = 1'b0;
    #1;
    check_out("rst", 1'b0, 32'd0, 4'd0);
    check_eq("rst.val", 64'(out_v), 64'd0);
    check_eq("rst.dest", 64'(out_d), 64'd0);
    check_eq("rst.ovf", 64'(ovf), 64'd0);
    check_eq("rst.full", 64'({alu_full, lsb_full, mul_full}), 64'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Single ALU push: visible only after the second edge, for one cycle.
    alu_f = 1'b1; alu_v = 32'h0000_002A; alu_d = 4'd3;
    tick(); idle();
    check_out("single.e1", 1'b0, 32'd0, 4'd0);
    tick(); check_out("single.e2", 1'b1, 32'h2A, 4'd3);
    tick(); check_out("single.e3", 1'b0, 32'd0, 4'd0);

    // Simultaneous pushes, pointer at ALU: LSB, MUL, ALU.
    push_all(32'h11, 4'd1, 32'h22, 4'd2, 32'h33, 4'd3);
    tick(); idle();
    check_out("rr.e1", 1'b0, 32'd0, 4'd0);
    tick(); check_out("rr.lsb", 1'b1, 32'h22, 4'd2);
    tick(); check_out("rr.mul", 1'b1, 32'h33, 4'd3);
    tick(); check_out("rr.alu", 1'b1, 32'h11, 4'd1);
    tick(); check_out("rr.idle", 1'b0, 32'd0, 4'd0);

    // Fill to full, drop a push into the full ALU queue, then drain.
    fill();
    check_eq("fill.aluFull", 64'(alu_full), 64'd1);
    check_eq("fill.lsbFull", 64'(lsb_full), 64'd0);
    check_eq("fill.mulFull", 64'(mul_full), 64'd1);
    check_eq("fill.ovf", 64'(ovf), 64'd0);
    alu_f = 1'b1; alu_v = 32'hDEAD; alu_d = 4'd15;
    tick(); idle();
    check_eq("drop.ovf", 64'(ovf), 64'd1);
    check_eq("drop.aluFull", 64'(alu_full), 64'd1);
    check_seq(4);
    for (int j = 5; j < 15; j++) begin
      tick(); check_seq(j);
    end
    tick(); check_out("drain.idle", 1'b0, 32'd0, 4'd0);
    check_eq("drain.full", 64'({alu_full, lsb_full, mul_full}), 64'd0);

    // Pointer wrap on the ALU queue with values 0..7.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        alu_f = 1'b1; alu_v = 32'(i); alu_d = 4'(i);
      end else begin
        idle();
      end
      tick();
      if (i > 0) check_out($sformatf("wrap%0d", i - 1), 1'b1, 32'(i - 1), 4'(i - 1));
    end
    tick(); check_out("wrap.idle", 1'b0, 32'd0, 4'd0);

    // Clear with queues occupied and a concurrent MUL push.
    push_all(32'h21, 4'd1, 32'h22, 4'd2, 32'h23, 4'd3);
    tick();
    push_all(32'h24, 4'd4, 32'h25, 4'd5, 32'h26, 4'd6);
    tick(); idle();
    check_out("clr.pre", 1'b1, 32'h22, 4'd2);
    clear = 1'b1; mul_f = 1'b1; mul_v = 32'h27; mul_d = 4'd7;
    tick(); idle();
    check_out("clr.e0", 1'b0, 32'd0, 4'd0);
    check_eq("clr.full", 64'({alu_full, lsb_full, mul_full}), 64'd0);
    check_eq("clr.ovf", 64'(ovf), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick(); check_out($sformatf("clr.idle%0d", i), 1'b0, 32'd0, 4'd0);
    end
    // Pointer back at ALU after the clear: LSB first again.
    push_all(32'h61, 4'd1, 32'h62, 4'd2, 32'h63, 4'd3);
    tick(); idle();
    tick(); check_out("clr.lsb", 1'b1, 32'h62, 4'd2);
    tick(); check_out("clr.mul", 1'b1, 32'h63, 4'd3);
    tick(); check_out("clr.alu", 1'b1, 32'h61, 4'd1);
    tick(); check_out("clr.end", 1'b0, 32'd0, 4'd0);

    // Freeze for 5 cycles mid-broadcast; pushes and clear must be ignored.
    alu_f = 1'b1; alu_v = 32'h55; alu_d = 4'd5;
    tick();
    push_all(32'h58, 4'd8, 32'h77, 4'd7, 32'h66, 4'd6);
    tick();
    check_out("frz.pre", 1'b1, 32'h55, 4'd5);
    ready = 1'b0; clear = 1'b1;
    push_all(32'h99, 4'd9, 32'h9A, 4'd10, 32'h9B, 4'd11);
    for (int i = 0; i < 5; i++) begin
      tick(); check_out($sformatf("frz%0d", i), 1'b1, 32'h55, 4'd5);
    end
    check_eq("frz.full", 64'({alu_full, lsb_full, mul_full}), 64'd0);
    ready = 1'b1; idle();
    tick(); check_out("frz.lsb", 1'b1, 32'h77, 4'd7);
    tick(); check_out("frz.mul", 1'b1, 32'h66, 4'd6);
    tick(); check_out("frz.alu", 1'b1, 32'h58, 4'd8);
    tick(); check_out("frz.end", 1'b0, 32'd0, 4'd0);

    // Asynchronous reset mid-cycle with full queues.
    fill();
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst.flag", 64'(out_f), 64'd0);
    check_eq("arst.val", 64'(out_v), 64'd0);
    check_eq("arst.dest", 64'(out_d), 64'd0);
    check_eq("arst.ovf", 64'(ovf), 64'd0);
    check_eq("arst.full", 64'({alu_full, lsb_full, mul_full}), 64'd0);
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("arst.idle%0d", i), 64'({out_f, out_v}), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
